// File: rtl/mips_hazard_pkg.sv
// Shared constants and helpers for the MIPS hazard controller.
// Forward-select encodings and the register-match primitive.
package mips_hazard_pkg;

    localparam logic [1:0] FWD_REG  = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;
    localparam logic [4:0] REG_ZERO = 5'd0;

    // r0 is hardwired, so it never creates a dependency
    function automatic logic reg_hit(
        input logic [4:0] src,
        input logic [4:0] dst,
        input logic       we
    );
        return we && (src != REG_ZERO) && (src == dst);
    endfunction

endpackage

// File: rtl/md_busy_timer.sv
// HI/LO busy timer: counts down the mult/div latency after issue.
// A new start reloads the count even if still busy.
module md_busy_timer #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic isdiv,
    output logic busy
);

    localparam int MAXL = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW   = $clog2(MAXL + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = isdiv ? CW'(DIV_LAT) : CW'(MULT_LAT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage MIPS pipeline: forwarding
// selects, load/branch/mult-div stalls and a stall-cycle counter.
module hazard_ctrl_unit
    import mips_hazard_pkg::*;
#(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic [4:0]       rsE,
    input  logic [4:0]       rtE,
    input  logic [4:0]       writeregE,
    input  logic [4:0]       writeregM,
    input  logic [4:0]       writeregW,
    input  logic             regwriteE,
    input  logic             regwriteM,
    input  logic             regwriteW,
    input  logic             memtoregE,
    input  logic             memtoregM,
    input  logic             branchD,
    input  logic             jrD,
    input  logic             mdopD,
    input  logic             hiloreadD,
    input  logic             mdstartE,
    input  logic             mdisdivE,
    output logic             forwardaD,
    output logic             forwardbD,
    output logic [1:0]       forwardaE,
    output logic [1:0]       forwardbE,
    output logic             stallF,
    output logic             stallD,
    output logic             flushE,
    output logic             mdbusy,
    output logic [CNT_W-1:0] stallcnt
);

    logic lwstall;
    logic brstall;
    logic mdstall;
    logic stall;

    logic [CNT_W-1:0] stallcnt_q;
    logic [CNT_W-1:0] stallcnt_d;

    md_busy_timer #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_timer (
        .clk   (clk),
        .reset (reset),
        .start (mdstartE),
        .isdiv (mdisdivE),
        .busy  (mdbusy)
    );

    // MEM result is newer than WB, so it takes priority
    always_comb begin
        forwardaE = FWD_REG;
        if (reg_hit(rsE, writeregM, regwriteM)) begin
            forwardaE = FWD_M;
        end else if (reg_hit(rsE, writeregW, regwriteW)) begin
            forwardaE = FWD_W;
        end
    end

    always_comb begin
        forwardbE = FWD_REG;
        if (reg_hit(rtE, writeregM, regwriteM)) begin
            forwardbE = FWD_M;
        end else if (reg_hit(rtE, writeregW, regwriteW)) begin
            forwardbE = FWD_W;
        end
    end

    assign forwardaD = reg_hit(rsD, writeregM, regwriteM);
    assign forwardbD = reg_hit(rtD, writeregM, regwriteM);

    assign lwstall = memtoregE &&
                     (reg_hit(rsD, writeregE, 1'b1) ||
                      reg_hit(rtD, writeregE, 1'b1));

    always_comb begin
        brstall = 1'b0;
        if (branchD) begin
            brstall = reg_hit(rsD, writeregE, regwriteE) ||
                      reg_hit(rtD, writeregE, regwriteE) ||
                      reg_hit(rsD, writeregM, memtoregM) ||
                      reg_hit(rtD, writeregM, memtoregM);
        end else if (jrD) begin
            brstall = reg_hit(rsD, writeregE, regwriteE) ||
                      reg_hit(rsD, writeregM, memtoregM);
        end
    end

    assign mdstall = (hiloreadD || mdopD) && (mdbusy || mdstartE);

    assign stall  = !reset && (lwstall || brstall || mdstall);
    assign stallF = stall;
    assign stallD = stall;
    assign flushE = stall;

    always_comb begin
        stallcnt_d = stallcnt_q;
        if (stall && (stallcnt_q != '1)) begin
            stallcnt_d = stallcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallcnt_q <= '0;
        end else begin
            stallcnt_q <= stallcnt_d;
        end
    end

    assign stallcnt = stallcnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: directed cases plus
// random traffic against a behavioural model of the hazard rules.
module tb_hazard_ctrl_unit;

    localparam int MULT_LAT = 4;
    localparam int DIV_LAT  = 32;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] rsD, rtD, rsE, rtE;
    logic [4:0] writeregE, writeregM, writeregW;
    logic regwriteE, regwriteM, regwriteW;
    logic memtoregE, memtoregM;
    logic branchD, jrD, mdopD, hiloreadD;
    logic mdstartE, mdisdivE;
    logic forwardaD, forwardbD;
    logic [1:0] forwardaE, forwardbE;
    logic stallF, stallD, flushE, mdbusy;
    logic [CNT_W-1:0] stallcnt;

    int errs = 0;
    int checks = 0;

    int cyc = 0;
    int busy_until = 0;
    int m_cnt = 0;

    hazard_ctrl_unit #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rsD       (rsD),
        .rtD       (rtD),
        .rsE       (rsE),
        .rtE       (rtE),
        .writeregE (writeregE),
        .writeregM (writeregM),
        .writeregW (writeregW),
        .regwriteE (regwriteE),
        .regwriteM (regwriteM),
        .regwriteW (regwriteW),
        .memtoregE (memtoregE),
        .memtoregM (memtoregM),
        .branchD   (branchD),
        .jrD       (jrD),
        .mdopD     (mdopD),
        .hiloreadD (hiloreadD),
        .mdstartE  (mdstartE),
        .mdisdivE  (mdisdivE),
        .forwardaD (forwardaD),
        .forwardbD (forwardbD),
        .forwardaE (forwardaE),
        .forwardbE (forwardbE),
        .stallF    (stallF),
        .stallD    (stallD),
        .flushE    (flushE),
        .mdbusy    (mdbusy),
        .stallcnt  (stallcnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at t=%0t",
                     tag, obs, exp, $time);
        end
    endtask

    // Reference model: plain rule evaluation
    function automatic bit same(input logic [4:0] a,
                                input logic [4:0] b);
        return (a != 0) && (a == b);
    endfunction

    function automatic logic [1:0] m_fwdE(input logic [4:0] src);
        if (regwriteM && same(src, writeregM)) return 2'd2;
        if (regwriteW && same(src, writeregW)) return 2'd1;
        return 2'd0;
    endfunction

    function automatic bit m_busy();
        return cyc < busy_until;
    endfunction

    function automatic bit m_stall();
        bit lw, br, jr, md;
        lw = memtoregE && (same(rsD, writeregE) || same(rtD, writeregE));
        br = branchD && ((regwriteE && (same(rsD, writeregE) ||
                                        same(rtD, writeregE))) ||
                         (memtoregM && (same(rsD, writeregM) ||
                                        same(rtD, writeregM))));
        jr = jrD && ((regwriteE && same(rsD, writeregE)) ||
                     (memtoregM && same(rsD, writeregM)));
        md = (hiloreadD || mdopD) && (m_busy() || mdstartE);
        return !reset && (lw || br || jr || md);
    endfunction

    task automatic check_all();
        bit s;
        @(negedge clk);
        s = m_stall();
        chk("fwdaE", 32'(forwardaE), 32'(m_fwdE(rsE)));
        chk("fwdbE", 32'(forwardbE), 32'(m_fwdE(rtE)));
        chk("fwdaD", 32'(forwardaD), 32'(regwriteM && same(rsD, writeregM)));
        chk("fwdbD", 32'(forwardbD), 32'(regwriteM && same(rtD, writeregM)));
        chk("stallF", 32'(stallF), 32'(s));
        chk("stallD", 32'(stallD), 32'(s));
        chk("flushE", 32'(flushE), 32'(s));
        chk("mdbusy", 32'(mdbusy), 32'(!reset && m_busy()));
        chk("stallcnt", 32'(stallcnt), 32'(m_cnt));
    endtask

    // Advance one clock and apply the edge to the model
    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            if (m_stall() && m_cnt < CNT_MAX) m_cnt++;
            if (mdstartE)
                busy_until = cyc + 1 + (mdisdivE ? DIV_LAT : MULT_LAT);
        end
        cyc++;
        #1;
    endtask

    task automatic clear_in();
        {rsD, rtD, rsE, rtE} = '0;
        {writeregE, writeregM, writeregW} = '0;
        {regwriteE, regwriteM, regwriteW} = '0;
        {memtoregE, memtoregM, branchD, jrD} = '0;
        {mdopD, hiloreadD, mdstartE, mdisdivE} = '0;
    endtask

    task automatic async_reset();
        reset = 1'b1;
        busy_until = 0;
        m_cnt = 0;
        #1;
        chk("rst_busy", 32'(mdbusy), 32'd0);
        chk("rst_cnt", 32'(stallcnt), 32'd0);
        chk("rst_stall", 32'(stallD), 32'd0);
    endtask

    initial begin
        int nstall;
        int nbusy;
        clear_in();
        reset = 1'b1;
        #2;
        chk("reset_cnt", 32'(stallcnt), 32'd0);
        chk("reset_busy", 32'(mdbusy), 32'd0);
        tick();
        tick();
        reset = 1'b0;

        // Forwarding priority and r0
        regwriteM = 1; writeregM = 8;
        regwriteW = 1; writeregW = 8; rsE = 8;
        check_all();
        chk("t1_memwins", 32'(forwardaE), 32'd2);
        tick();
        rsE = 0; writeregM = 0;
        check_all();
        chk("t1_r0", 32'(forwardaE), 32'd0);
        tick();

        // Load-use stall
        clear_in();
        memtoregE = 1; writeregE = 9; rsD = 9;
        check_all();
        chk("t2_stall", 32'(stallD), 32'd1);
        tick();
        clear_in();
        check_all();
        chk("t2_cnt", 32'(stallcnt), 32'd1);
        tick();

        // Branch operand hazards
        branchD = 1; rtD = 5; regwriteE = 1; writeregE = 5;
        check_all();
        chk("t3_exstall", 32'(stallD), 32'd1);
        tick();
        regwriteE = 0; writeregE = 0;
        memtoregM = 1; writeregM = 5;
        check_all();
        chk("t3_ldstall", 32'(stallD), 32'd1);
        tick();
        memtoregM = 0; regwriteM = 1;
        check_all();
        chk("t3_fwd", 32'(forwardbD), 32'd1);
        chk("t3_nostall", 32'(stallD), 32'd0);
        tick();

        // Mult latency with mfhi waiting
        clear_in();
        async_reset();
        tick();
        reset = 1'b0;
        hiloreadD = 1; mdstartE = 1; mdisdivE = 0;
        nstall = 0;
        nbusy = 0;
        for (int i = 0; i < 12; i++) begin
            check_all();
            if (stallD) nstall++;
            if (mdbusy) nbusy++;
            tick();
            mdstartE = 0;
        end
        chk("t4_stalls", 32'(nstall), 32'd5);
        chk("t4_busy", 32'(nbusy), 32'd4);

        // Reset in the middle of a div
        clear_in();
        hiloreadD = 1; mdstartE = 1; mdisdivE = 1;
        check_all();
        tick();
        mdstartE = 0;
        for (int i = 0; i < 12; i++) begin
            check_all();
            tick();
        end
        chk("t5_pre", 32'(stallD), 32'd1);
        async_reset();
        check_all();
        tick();
        reset = 1'b0;
        check_all();
        chk("t5_after", 32'(stallD), 32'd0);
        tick();

        // Counter saturation
        clear_in();
        async_reset();
        tick();
        reset = 1'b0;
        memtoregE = 1; writeregE = 9; rsD = 9;
        for (int i = 0; i < 20; i++) begin
            check_all();
            tick();
        end
        chk("t6_sat", 32'(stallcnt), 32'd15);
        clear_in();
        check_all();
        tick();
        chk("t6_hold", 32'(stallcnt), 32'd15);

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            if (n % 64 == 63) begin
                async_reset();
                tick();
                reset = 1'b0;
            end
            rsD = 5'($urandom_range(0, 7));
            rtD = 5'($urandom_range(0, 7));
            rsE = 5'($urandom_range(0, 7));
            rtE = 5'($urandom_range(0, 7));
            writeregE = 5'($urandom_range(0, 7));
            writeregM = 5'($urandom_range(0, 7));
            writeregW = 5'($urandom_range(0, 7));
            regwriteE = 1'($urandom_range(0, 1));
            regwriteM = 1'($urandom_range(0, 1));
            regwriteW = 1'($urandom_range(0, 1));
            memtoregE = ($urandom_range(0, 3) == 0);
            memtoregM = ($urandom_range(0, 3) == 0);
            branchD = ($urandom_range(0, 3) == 0);
            jrD = ($urandom_range(0, 5) == 0);
            mdopD = ($urandom_range(0, 7) == 0);
            hiloreadD = ($urandom_range(0, 3) == 0);
            mdstartE = ($urandom_range(0, 15) == 0);
            mdisdivE = 1'($urandom_range(0, 1));
            check_all();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
